// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send and shifts one
// command byte out on device-generated clock edges, driving the pins only through open-drain enables.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int RTS_CYCLES     = 10,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       rx_inhibit,
    output logic       done,
    output logic       error
);

    localparam int PH_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [PH_W-1:0] INH_LAST = PH_W'(INHIBIT_CYCLES - 1);
    localparam logic [PH_W-1:0] RTS_LAST = PH_W'(RTS_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t          state;
    logic [1:0]      clk_sync;
    logic [1:0]      dat_sync;
    logic            clk_prev;
    logic            fe;
    logic            watch;
    logic            timed_out;
    logic [7:0]      data_reg;
    logic            parity_reg;
    logic [3:0]      bit_cnt;
    logic            nack;
    logic [PH_W-1:0] ph_cnt;
    logic [TO_W-1:0] to_cnt;

    // Synchronisers reset to the idle-high bus level so no false edge appears after reset.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DAT};
            clk_prev <= clk_sync[1];
        end
    end

    assign fe         = clk_prev & ~clk_sync[1];
    assign watch      = (state == SEND) || (state == ACK) || (state == WAIT_IDLE);
    assign timed_out  = (to_cnt == TO_LAST);
    assign rx_inhibit = busy;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            data_reg   <= 8'h00;
            parity_reg <= 1'b0;
            bit_cnt    <= 4'd0;
            nack       <= 1'b0;
            ph_cnt     <= '0;
            to_cnt     <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (watch && timed_out) begin
                ps2_clk_oe <= 1'b0;
                ps2_dat_oe <= 1'b0;
                done       <= 1'b1;
                error      <= 1'b1;
                state      <= IDLE;
            end else begin
                if (watch) begin
                    to_cnt <= to_cnt + 1'b1;
                end
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                        if (tx_start && !busy) begin
                            data_reg   <= tx_data;
                            parity_reg <= ~^tx_data;
                            ph_cnt     <= '0;
                            busy       <= 1'b1;
                            ps2_clk_oe <= 1'b1;
                            ps2_dat_oe <= 1'b0;
                            state      <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (ph_cnt == INH_LAST) begin
                            ph_cnt     <= '0;
                            ps2_dat_oe <= 1'b1;
                            state      <= RTS;
                        end else begin
                            ph_cnt <= ph_cnt + 1'b1;
                        end
                    end
                    RTS: begin
                        if (ph_cnt == RTS_LAST) begin
                            ps2_clk_oe <= 1'b0;
                            bit_cnt    <= 4'd0;
                            to_cnt     <= '0;
                            state      <= SEND;
                        end else begin
                            ph_cnt <= ph_cnt + 1'b1;
                        end
                    end
                    // Each device falling edge presents the next bit: data LSB first, parity, then stop.
                    SEND: begin
                        if (fe) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt < 4'd8) begin
                                ps2_dat_oe <= ~data_reg[bit_cnt[2:0]];
                            end else if (bit_cnt == 4'd8) begin
                                ps2_dat_oe <= ~parity_reg;
                            end else begin
                                ps2_dat_oe <= 1'b0;
                                state      <= ACK;
                            end
                        end
                    end
                    ACK: begin
                        if (fe) begin
                            nack  <= dat_sync[1];
                            state <= WAIT_IDLE;
                        end
                    end
                    WAIT_IDLE: begin
                        if (clk_sync[1] && dat_sync[1]) begin
                            done  <= 1'b1;
                            error <= nack;
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a behavioural keyboard clocks the byte out and a scoreboard
// compares each captured frame against the expectation queued when the transfer was started.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INHIBIT = 20;
    localparam int RTS     = 4;
    localparam int TIMEOUT = 2000;
    localparam int HALF    = 20;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_start = 1'b0;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       busy;
    logic       rx_inhibit;
    logic       done;
    logic       error;

    logic dev_clk    = 1'b1;
    logic dev_dat    = 1'b1;
    logic dev_enable = 1'b1;
    logic dev_nack   = 1'b0;
    logic dev_active = 1'b0;
    logic cap_valid  = 1'b0;
    logic [9:0] cap_bits = 10'h000;
    int dev_idx = -1;

    int check_cnt  = 0;
    int fail_cnt   = 0;
    int inh_cycles = 0;
    int rts_cycles = 0;
    int done_cnt   = 0;
    int violations = 0;
    logic busy_d    = 1'b0;
    logic phase_pre = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       parity;
        logic       err;
        logic       timeout;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [7:0] data;
        logic       nack;
        logic       exp_par;
        logic       exp_err;
    } vec_t;
    vec_t vecs[6];

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .RTS_CYCLES    (RTS),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .busy      (busy),
        .rx_inhibit(rx_inhibit),
        .done      (done),
        .error     (error)
    );

    assign PS2_CLK = dev_clk & ~ps2_clk_oe;
    assign PS2_DAT = dev_dat & ~ps2_dat_oe;

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_cnt++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic dev_half();
        for (int k = 0; k < HALF; k++) begin
            @(negedge CLOCK_50);
            if (!dev_enable) dev_active = 1'b0;
        end
    endtask

    // Keyboard model: answers request-to-send with 11 clock pulses, sampling on each rising edge.
    always begin
        @(negedge CLOCK_50);
        if (dev_enable && reset && PS2_CLK && !PS2_DAT) begin
            dev_active = 1'b1;
            cap_valid  = 1'b0;
            for (int i = 0; i < 11 && dev_active; i++) begin
                dev_idx = i;
                if (i == 10 && !dev_nack) dev_dat = 1'b0;
                dev_half();
                dev_clk = 1'b0;
                dev_half();
                dev_clk = 1'b1;
                if (i < 10) cap_bits[i] = PS2_DAT;
                if (i == 9) cap_valid = dev_active;
            end
            dev_clk    = 1'b1;
            dev_dat    = 1'b1;
            dev_idx    = -1;
            dev_active = 1'b0;
        end
    end

    // Phase counters and the rule that both lines are never released before the start bit.
    always @(negedge CLOCK_50) begin
        if (ps2_clk_oe && !ps2_dat_oe) inh_cycles++;
        if (ps2_clk_oe && ps2_dat_oe) rts_cycles++;
        if (done) done_cnt++;
        if (busy && !busy_d) phase_pre = 1'b1;
        if (!ps2_clk_oe && ps2_dat_oe) phase_pre = 1'b0;
        if (busy && phase_pre && !ps2_clk_oe && !ps2_dat_oe) violations++;
        busy_d = busy;
    end

    task automatic applyStimulus(input logic [7:0] data, input logic exp_par, input logic exp_err,
                                 input logic is_timeout, input string tag);
        exp_t e;
        @(negedge CLOCK_50);
        inh_cycles = 0;
        rts_cycles = 0;
        tx_data  = data;
        tx_start = 1'b1;
        e.data    = data;
        e.parity  = exp_par;
        e.err     = exp_err;
        e.timeout = is_timeout;
        sb_q.push_back(e);
        @(negedge CLOCK_50);
        tx_start = 1'b0;
        tx_data  = ~data;
        checkOutput({tag, "_busy_rise"}, busy, 1);
        checkOutput({tag, "_rx_inhibit"}, rx_inhibit, 1);
    endtask

    task automatic waitDone(input string tag, input bit check_phase);
        bit   seen;
        exp_t e;
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge CLOCK_50);
            if (done) seen = 1'b1;
        end
        checkOutput({tag, "_done_seen"}, seen, 1);
        if (seen) begin
            checkOutput({tag, "_busy_at_done"}, busy, 1);
            if (sb_q.size() == 0) begin
                checkOutput({tag, "_sb_entry"}, 0, 1);
            end else begin
                e = sb_q.pop_front();
                checkOutput({tag, "_error"}, error, e.err);
                if (!e.timeout) begin
                    checkOutput({tag, "_cap_valid"}, cap_valid, 1);
                    checkOutput({tag, "_data"}, cap_bits[7:0], e.data);
                    checkOutput({tag, "_parity"}, cap_bits[8], e.parity);
                    checkOutput({tag, "_stop"}, cap_bits[9], 1);
                end
            end
            @(negedge CLOCK_50);
            checkOutput({tag, "_busy_drop"}, busy, 0);
            checkOutput({tag, "_done_pulse"}, done, 0);
        end
        if (check_phase) begin
            checkOutput({tag, "_inhibit_cycles"}, inh_cycles, INHIBIT);
            checkOutput({tag, "_rts_cycles"}, rts_cycles, RTS);
        end
    endtask

    initial begin
        int   done_before;
        int   cnt;
        bit   found;
        exp_t e;

        vecs[0] = '{8'hED, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h01, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'h3C, 1'b1, 1'b1, 1'b1};

        repeat (3) @(negedge CLOCK_50);
        checkOutput("reset_outputs", {ps2_clk_oe, ps2_dat_oe, busy, rx_inhibit, done, error}, 0);
        reset = 1'b1;
        repeat (5) @(negedge CLOCK_50);

        for (int i = 0; i < 6; i++) begin
            dev_nack = vecs[i].nack;
            applyStimulus(vecs[i].data, vecs[i].exp_par, vecs[i].exp_err, 1'b0, $sformatf("v%0d", i));
            waitDone($sformatf("v%0d", i), 1'b1);
            repeat (5) @(negedge CLOCK_50);
        end
        dev_nack = 1'b0;

        // A second request mid-transfer must be dropped without disturbing the byte in flight.
        done_before = done_cnt;
        applyStimulus(8'h96, 1'b1, 1'b0, 1'b0, "busy_ign");
        found = 1'b0;
        for (int k = 0; k < 500 && !found; k++) begin
            @(negedge CLOCK_50);
            if (dev_idx == 2) found = 1'b1;
        end
        checkOutput("busy_ign_reach_bit", found, 1);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge CLOCK_50);
        tx_start = 1'b0;
        tx_data  = 8'hAA;
        waitDone("busy_ign", 1'b0);
        repeat (100) @(negedge CLOCK_50);
        checkOutput("busy_ign_one_done", done_cnt - done_before, 1);
        checkOutput("busy_ign_idle", busy, 0);

        // Silent device: the watchdog must fire a fixed number of cycles after clk release.
        dev_enable = 1'b0;
        applyStimulus(8'h5A, 1'b1, 1'b1, 1'b1, "timeout");
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge CLOCK_50);
            if (!ps2_clk_oe && ps2_dat_oe) found = 1'b1;
        end
        checkOutput("timeout_send_entry", found, 1);
        cnt = 0;
        for (int k = 0; k < 2500 && !done; k++) begin
            @(negedge CLOCK_50);
            cnt++;
        end
        checkOutput("timeout_cycles", cnt, TIMEOUT);
        checkOutput("timeout_lines", {ps2_clk_oe, ps2_dat_oe}, 0);
        checkOutput("timeout_error", error, 1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            checkOutput("timeout_sb_err", error, e.err);
        end else begin
            checkOutput("timeout_sb_entry", 0, 1);
        end
        @(negedge CLOCK_50);
        checkOutput("timeout_busy_drop", busy, 0);
        dev_enable = 1'b1;
        repeat (10) @(negedge CLOCK_50);

        // Reset during bit 4: lines and busy drop asynchronously and no completion is reported.
        applyStimulus(8'hC3, 1'b1, 1'b0, 1'b0, "rst_mid");
        found = 1'b0;
        for (int k = 0; k < 500 && !found; k++) begin
            @(negedge CLOCK_50);
            if (dev_idx == 4 && !dev_clk) found = 1'b1;
        end
        checkOutput("rst_mid_reach_bit4", found, 1);
        repeat (5) @(negedge CLOCK_50);
        done_before = done_cnt;
        #3 reset = 1'b0;
        #1 checkOutput("rst_mid_async", {ps2_clk_oe, ps2_dat_oe, busy}, 0);
        sb_q.delete();
        dev_enable = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge CLOCK_50);
            if (!dev_active) found = 1'b1;
        end
        checkOutput("rst_mid_dev_idle", found, 1);
        dev_enable = 1'b1;
        repeat (10) @(negedge CLOCK_50);
        checkOutput("rst_mid_no_done", done_cnt - done_before, 0);
        reset = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0, "post_rst");
        waitDone("post_rst", 1'b1);

        checkOutput("lines_released_pre_send", violations, 0);

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule
